// File: rtl/data_memory_responder.sv
// Data memory responder: a 16-bit wide, 2^ADDR_BITS deep word memory.
// After every reset it runs a clear sweep that zeroes one word per cycle,
// then serves single-cycle-latency reads and level-sensitive writes.
// Optional memory-mapped I/O is enabled by defining DMEM_IO_EN. When it is
// defined, address 16'hFFFF drives LedOut on writes and returns synchronized
// SwitchIn on reads.
module data_memory_responder #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Daddress,
  input  logic [15:0] Dout,
  input  logic        W,
  output logic [15:0] DataIn,
  output logic        Ready
`ifdef DMEM_IO_EN
  ,
  input  logic [15:0] SwitchIn,
  output logic [15:0] LedOut
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  state_e               state_q;
  logic [ADDR_BITS-1:0] init_addr_q;

  // Storage is never reset; only the sweep clears it.
  logic [15:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] index;
  logic                 io_hit;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [15:0]          mem_wdata;
  logic [15:0]          read_data;

  // Upper address bits are deliberately ignored so addresses alias modulo DEPTH.
  assign index = Daddress[ADDR_BITS-1:0];

`ifdef DMEM_IO_EN
  localparam logic [15:0] IoAddr = 16'hFFFF;

  logic [15:0] sw_meta_q;
  logic [15:0] sw_sync_q;

  // The I/O decode needs the full address, not just the index bits.
  assign io_hit = (Daddress == IoAddr);

  // Two-flop synchronizer for the external switch port, plus the LED register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      LedOut    <= '0;
    end else begin
      sw_meta_q <= SwitchIn;
      sw_sync_q <= sw_meta_q;
      if ((state_q == StRun) && W && io_hit) begin
        LedOut <= Dout;
      end
    end
  end
`else
  logic unused_addr;

  assign io_hit      = 1'b0;
  assign unused_addr = ^Daddress;
`endif

  // Write port mux: the sweep owns the port in INIT, the processor in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = index;
    mem_wdata = Dout;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr_q;
      mem_wdata = '0;
    end else if (W && !io_hit) begin
      mem_we = 1'b1;
    end
  end

  // Memory array write; no reset on the storage cells.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read data selection: write-first bypass for memory, synchronizer for I/O.
  always_comb begin
    read_data = mem[index];
    if (W && !io_hit) begin
      read_data = Dout;
    end
`ifdef DMEM_IO_EN
    if (io_hit) begin
      read_data = sw_sync_q;
    end
`endif
  end

  // Control FSM with registered Ready and DataIn; sweeps one word per cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StInit;
      init_addr_q <= '0;
      DataIn      <= '0;
      Ready       <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          DataIn      <= '0;
          init_addr_q <= init_addr_q + 1'b1;
          // The last word is written on this edge, so RUN starts next cycle.
          if (init_addr_q == '1) begin
            state_q <= StRun;
            Ready   <= 1'b1;
          end
        end
        StRun: begin
          DataIn <= read_data;
        end
      endcase
    end
  end

  // Ready mirrors the state, and read data stays zero throughout the sweep.
  ready_matches_state_a : assert property (
    @(posedge Clock) disable iff (Reset) Ready == (state_q == StRun)
  );

  init_data_zero_a : assert property (
    @(posedge Clock) disable iff (Reset) (state_q == StInit) |-> (DataIn == '0)
  );

endmodule
